mandel_point_scheduler: RTL and testbench
=========================================

# mandel_point_scheduler

Frame-level scheduler for a bank of Mandelbrot point-generator units. Walks the pixel raster for the configured resolution, issues one (x, y) job per cycle to free units round-robin, captures each unit's iteration count, and streams results out strictly in raster order over a valid/ready port. Sits between the render-control/parameter logic and the frame output path.

## Interface
- NUM_UNITS, 4, number of point-generator units (1..16)
- HBI, 32, iteration-count width
- CW, 12, x/y coordinate width
- CLK  in  1  system clock
- SYS_RESET_N  in  1  asynchronous active-low reset
- frame_start  in  1  pulse; starts a frame when idle
- x_size  in  11  pixels per line, sampled on accepted frame_start
- y_size  in  11  lines per frame, sampled on accepted frame_start
- busy  out  1  high from accepted frame_start until frame_done
- frame_done  out  1  one-cycle pulse after last result is accepted
- unit_start  out  NUM_UNITS  one-cycle start pulse per unit
- unit_x  out  NUM_UNITS*CW  per-unit x, held from start until next start
- unit_y  out  NUM_UNITS*CW  per-unit y, same hold rule
- unit_done  in  NUM_UNITS  per-unit done level, held until next start
- unit_iter  in  NUM_UNITS*HBI  per-unit iteration count, valid while done
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  HBI  iteration count for current pixel
- out_last  out  1  high with final pixel of frame
- frame_cycles  out  32  cycles of last completed frame (see Configuration)

## Operation
- Frame FSM: IDLE -> RUN on frame_start; RUN -> DRAIN when last pixel issued; DRAIN -> DONE when last result accepted; DONE -> IDLE unconditionally (frame_done high in DONE).
- frame_start outside IDLE ignored. x_size==0 or y_size==0: IDLE -> DONE directly, no jobs, no output.
- Per-unit slot state: FREE, BUSY, HOLD. Reset: all FREE.
- Issue (RUN only): if slot[issue_ptr] FREE, pulse unit_start[issue_ptr], drive coordinates, slot -> BUSY, issue_ptr = (issue_ptr+1) mod NUM_UNITS, raster advance: x+1, or x=0,y+1 when x==x_size-1. Otherwise stall; pointer does not skip.
- Capture: slot BUSY and unit_done high -> register unit_iter, slot -> HOLD. unit_done ignored in the unit_start cycle and in FREE/HOLD.
- Output: out_valid = slot[out_ptr] is HOLD; out_data = that slot's result. On out_valid && out_ready: slot -> FREE, out_ptr advances mod NUM_UNITS, result counter increments. Round-robin issue and retire guarantee raster order regardless of completion order.
- out_last = out_valid and result counter == x_size*y_size-1 (22-bit product, computed once at frame start).
- out_valid does not depend combinationally on out_ready; once high, stays high with stable out_data until accepted.

## Timing
- Reset values: busy 0, frame_done 0, unit_start 0, unit_x/unit_y 0, out_valid 0, out_data 0, out_last 0, frame_cycles 0; pointers, raster, counters 0; FSM IDLE.
- frame_start at cycle 0 -> busy and first unit_start[0] at cycle 1 (x=0,y=0); with all slots free, unit_start[k] at cycle 1+k.
- unit_done seen at cycle t -> slot HOLD, out_valid (if slot is out_ptr) at t+1.
- Slot freed by acceptance at t is issuable at t+1, not t.
- Last acceptance at t -> frame_done and busy low at t+1; frame_start accepted at t+2 earliest.
- Reset mid-frame: everything returns to reset values immediately; results from in-flight units after reset are ignored (slots FREE).

## Configuration
- MANDEL_SCHED_PERF_EN defined: 32-bit counter runs while busy, saturates at 2^32-1, latched to frame_cycles in DONE.
- Undefined: counter not built, frame_cycles tied to 0.

## Structure
- Package mandel_sched_pkg: frame FSM enum, slot state enum, CW/HBI defaults, max raster width constants.
- Sub-module mandel_sched_slot: one per unit via generate; holds slot state, coordinates, result register; exposes free/hold flags.

## Test plan
- 4x2 frame, NUM_UNITS=4, units done after fixed 5 cycles, out_ready=1 -> 8 results in order (0,0)..(3,1), out_last on 8th, frame_done one cycle later.
- Units finish out of order (unit 2 at 3 cycles, unit 0 at 20) -> out_data still in raster order; unit 2 result held until units 0,1 retired.
- out_ready low 10 cycles with all slots HOLD -> no unit_start issued, out_data stable, no loss; resumes on ready.
- x_size=0 -> busy/frame_done sequence with zero unit_start and zero out_valid.
- SYS_RESET_N pulsed mid-frame after 5 issues -> all outputs at reset values; following frame_start produces full correct frame.
- MANDEL_SCHED_PERF_EN on, 640x480 with 1-cycle units -> frame_cycles equals measured busy duration; off -> frame_cycles 0.

Source files
------------

// File: rtl/mandel_sched_pkg.sv
// ---------------------------------------------------------------------------
// mandel_sched_pkg
// Shared types and constants for the Mandelbrot point scheduler:
//   - frame_state_t : frame-level FSM states
//   - slot_state_t  : per-unit slot occupancy states
//   - CW_DEF/HBI_DEF: default coordinate / iteration-count widths
//   - RASTER_W/PIX_W: raster dimension width and pixel-count width
//   - sat_inc32     : saturating 32-bit increment (frame cycle counter)
// ---------------------------------------------------------------------------
package mandel_sched_pkg;

    localparam int CW_DEF   = 12;
    localparam int HBI_DEF  = 32;
    localparam int RASTER_W = 11;
    localparam int PIX_W    = 2 * RASTER_W;

    typedef enum logic [1:0] {
        FRM_IDLE  = 2'd0,
        FRM_RUN   = 2'd1,
        FRM_DRAIN = 2'd2,
        FRM_DONE  = 2'd3
    } frame_state_t;

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_BUSY = 2'd1,
        SLOT_HOLD = 2'd2
    } slot_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        sat_inc32 = (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/mandel_point_scheduler_if.sv
// ---------------------------------------------------------------------------
// mandel_point_scheduler_if
// Result stream from the scheduler to the frame output path.
//   out_valid : result available (producer)
//   out_ready : consumer accepts (consumer)
//   out_data  : iteration count for the current pixel (producer)
//   out_last  : final pixel of the frame (producer)
// Modports: master = scheduler side, slave = consumer side.
// ---------------------------------------------------------------------------
interface mandel_point_scheduler_if #(
    parameter int HBI = 32
) ();
    logic           out_valid;
    logic           out_ready;
    logic [HBI-1:0] out_data;
    logic           out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/mandel_sched_slot.sv
// ---------------------------------------------------------------------------
// mandel_sched_slot
// Bookkeeping for one point-generator unit: FREE -> BUSY on issue,
// BUSY -> HOLD when the unit reports done, HOLD -> FREE on retire.
// Ports:
//   CLK, SYS_RESET_N       clock, async active-low reset
//   issue, issue_x/_y      start a job with these coordinates (slot is FREE)
//   retire                 result accepted downstream (slot is HOLD)
//   unit_done, unit_iter   unit completion level and iteration count
//   unit_start             registered one-cycle start pulse to the unit
//   unit_x, unit_y         coordinates held from start until next start
//   result                 captured iteration count
//   is_free, is_hold       slot state flags
// ---------------------------------------------------------------------------
module mandel_sched_slot
    import mandel_sched_pkg::*;
#(
    parameter int CW  = CW_DEF,
    parameter int HBI = HBI_DEF
) (
    input  logic           CLK,
    input  logic           SYS_RESET_N,
    input  logic           issue,
    input  logic [CW-1:0]  issue_x,
    input  logic [CW-1:0]  issue_y,
    input  logic           retire,
    input  logic           unit_done,
    input  logic [HBI-1:0] unit_iter,
    output logic           unit_start,
    output logic [CW-1:0]  unit_x,
    output logic [CW-1:0]  unit_y,
    output logic [HBI-1:0] result,
    output logic           is_free,
    output logic           is_hold
);

    slot_state_t    state_r;
    logic           start_r;
    logic [CW-1:0]  x_r;
    logic [CW-1:0]  y_r;
    logic [HBI-1:0] result_r;

    // Slot state, coordinate hold and result capture.
    always_ff @(posedge CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            state_r  <= SLOT_FREE;
            start_r  <= 1'b0;
            x_r      <= '0;
            y_r      <= '0;
            result_r <= '0;
        end else begin
            start_r <= issue;
            case (state_r)
                SLOT_FREE: begin
                    if (issue) begin
                        state_r <= SLOT_BUSY;
                        x_r     <= issue_x;
                        y_r     <= issue_y;
                    end
                end
                SLOT_BUSY: begin
                    // unit_done still reflects the previous job while the
                    // start pulse is out, so it is not trusted in that cycle.
                    if (unit_done && !start_r) begin
                        result_r <= unit_iter;
                        state_r  <= SLOT_HOLD;
                    end
                end
                SLOT_HOLD: begin
                    if (retire) begin
                        state_r <= SLOT_FREE;
                    end
                end
                default: begin
                    state_r <= SLOT_FREE;
                end
            endcase
        end
    end

    assign unit_start = start_r;
    assign unit_x     = x_r;
    assign unit_y     = y_r;
    assign result     = result_r;
    assign is_free    = (state_r == SLOT_FREE);
    assign is_hold    = (state_r == SLOT_HOLD);

endmodule

// File: rtl/mandel_point_scheduler.sv
// ---------------------------------------------------------------------------
// mandel_point_scheduler
// Walks the pixel raster, issues one (x, y) job per cycle to free units in
// round-robin order, captures iteration counts and streams them out in
// raster order. Issue and retire both walk the units in the same fixed
// order, which is what keeps the output in raster order.
// Ports:
//   CLK, SYS_RESET_N        clock, async active-low reset
//   frame_start             start a frame (honoured only when idle)
//   x_size, y_size          frame geometry, sampled on accepted frame_start
//   busy, frame_done        frame in progress / one-cycle completion pulse
//   unit_start/_x/_y        per-unit job start pulse and coordinates
//   unit_done, unit_iter    per-unit completion level and iteration count
//   out_if (master)         out_valid/out_ready/out_data/out_last stream
//   frame_cycles            busy cycles of the last completed frame
// Build option: MANDEL_SCHED_PERF_EN enables the frame cycle counter;
// without it frame_cycles is tied to zero.
// ---------------------------------------------------------------------------
module mandel_point_scheduler
    import mandel_sched_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int HBI       = HBI_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic                    CLK,
    input  logic                    SYS_RESET_N,
    input  logic                    frame_start,
    input  logic [RASTER_W-1:0]     x_size,
    input  logic [RASTER_W-1:0]     y_size,
    output logic                    busy,
    output logic                    frame_done,
    output logic [NUM_UNITS-1:0]    unit_start,
    output logic [NUM_UNITS*CW-1:0] unit_x,
    output logic [NUM_UNITS*CW-1:0] unit_y,
    input  logic [NUM_UNITS-1:0]    unit_done,
    input  logic [NUM_UNITS*HBI-1:0] unit_iter,
    mandel_point_scheduler_if.master out_if,
    output logic [31:0]             frame_cycles
);

    localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [PW-1:0] PTR_MAX = PW'(NUM_UNITS - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PTR_MAX) ? '0 : (p + PW'(1'b1));
    endfunction

    frame_state_t        state_r;
    logic                busy_r;
    logic                frame_done_r;
    logic [RASTER_W-1:0] xs_r;
    logic [RASTER_W-1:0] ys_r;
    logic [PIX_W-1:0]    total_m1_r;
    logic [PIX_W-1:0]    res_cnt_r;
    logic [PW-1:0]       issue_ptr_r;
    logic [PW-1:0]       out_ptr_r;
    logic [RASTER_W-1:0] x_r;
    logic [RASTER_W-1:0] y_r;

    logic                start_acc_s;
    logic                size_zero_s;
    logic [PW-1:0]       issue_idx_s;
    logic [RASTER_W-1:0] cur_x_s;
    logic [RASTER_W-1:0] cur_y_s;
    logic [RASTER_W-1:0] lim_x_s;
    logic [RASTER_W-1:0] lim_y_s;
    logic                can_issue_s;
    logic                issue_go_s;
    logic                line_end_s;
    logic                last_pix_s;
    logic                out_valid_s;
    logic                accept_s;
    logic                last_res_s;
    logic [NUM_UNITS-1:0] free_s;
    logic [NUM_UNITS-1:0] hold_s;
    logic [NUM_UNITS-1:0] issue_s;
    logic [NUM_UNITS-1:0] retire_s;
    logic [HBI-1:0]       result_s [NUM_UNITS];

    // The first job goes out in the same cycle frame_start is accepted, so
    // in that cycle the raster origin and the incoming sizes are used
    // directly instead of the (not yet loaded) registers.
    assign start_acc_s = (state_r == FRM_IDLE) && frame_start;
    assign size_zero_s = (x_size == {RASTER_W{1'b0}}) || (y_size == {RASTER_W{1'b0}});
    assign issue_idx_s = start_acc_s ? {PW{1'b0}} : issue_ptr_r;
    assign cur_x_s     = start_acc_s ? {RASTER_W{1'b0}} : x_r;
    assign cur_y_s     = start_acc_s ? {RASTER_W{1'b0}} : y_r;
    assign lim_x_s     = start_acc_s ? x_size : xs_r;
    assign lim_y_s     = start_acc_s ? y_size : ys_r;
    assign can_issue_s = (start_acc_s && !size_zero_s) || (state_r == FRM_RUN);
    assign issue_go_s  = can_issue_s && free_s[issue_idx_s];
    assign line_end_s  = (cur_x_s == (lim_x_s - RASTER_W'(1'b1)));
    assign last_pix_s  = line_end_s && (cur_y_s == (lim_y_s - RASTER_W'(1'b1)));

    assign out_valid_s = hold_s[out_ptr_r];
    assign accept_s    = out_valid_s && out_if.out_ready;
    assign last_res_s  = (res_cnt_r == total_m1_r);

    genvar g;
    generate
        for (g = 0; g < NUM_UNITS; g++) begin : g_slot
            assign issue_s[g]  = issue_go_s && (issue_idx_s == PW'(g));
            assign retire_s[g] = accept_s && (out_ptr_r == PW'(g));

            mandel_sched_slot #(
                .CW  (CW),
                .HBI (HBI)
            ) u_slot (
                .CLK         (CLK),
                .SYS_RESET_N (SYS_RESET_N),
                .issue       (issue_s[g]),
                .issue_x     (CW'(cur_x_s)),
                .issue_y     (CW'(cur_y_s)),
                .retire      (retire_s[g]),
                .unit_done   (unit_done[g]),
                .unit_iter   (unit_iter[g*HBI +: HBI]),
                .unit_start  (unit_start[g]),
                .unit_x      (unit_x[g*CW +: CW]),
                .unit_y      (unit_y[g*CW +: CW]),
                .result      (result_s[g]),
                .is_free     (free_s[g]),
                .is_hold     (hold_s[g])
            );
        end
    endgenerate

    // Frame sequencing, geometry capture and the busy/frame_done flags.
    always_ff @(posedge CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            state_r      <= FRM_IDLE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            xs_r         <= '0;
            ys_r         <= '0;
            total_m1_r   <= '0;
        end else begin
            case (state_r)
                FRM_IDLE: begin
                    frame_done_r <= 1'b0;
                    if (frame_start) begin
                        xs_r       <= x_size;
                        ys_r       <= y_size;
                        total_m1_r <= (PIX_W'(x_size) * PIX_W'(y_size)) - PIX_W'(1'b1);
                        if (size_zero_s) begin
                            state_r      <= FRM_DONE;
                            frame_done_r <= 1'b1;
                        end else begin
                            busy_r  <= 1'b1;
                            // A 1x1 frame is fully issued by its first job.
                            state_r <= (issue_go_s && last_pix_s) ? FRM_DRAIN : FRM_RUN;
                        end
                    end
                end
                FRM_RUN: begin
                    if (issue_go_s && last_pix_s) begin
                        state_r <= FRM_DRAIN;
                    end
                end
                FRM_DRAIN: begin
                    if (accept_s && last_res_s) begin
                        state_r      <= FRM_DONE;
                        busy_r       <= 1'b0;
                        frame_done_r <= 1'b1;
                    end
                end
                FRM_DONE: begin
                    state_r      <= FRM_IDLE;
                    frame_done_r <= 1'b0;
                end
                default: begin
                    state_r      <= FRM_IDLE;
                    busy_r       <= 1'b0;
                    frame_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Issue pointer and raster position of the next pixel to hand out.
    always_ff @(posedge CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            issue_ptr_r <= '0;
            x_r         <= '0;
            y_r         <= '0;
        end else if (issue_go_s) begin
            issue_ptr_r <= ptr_inc(issue_idx_s);
            x_r         <= line_end_s ? {RASTER_W{1'b0}} : (cur_x_s + RASTER_W'(1'b1));
            y_r         <= line_end_s ? (cur_y_s + RASTER_W'(1'b1)) : cur_y_s;
        end else if (start_acc_s) begin
            issue_ptr_r <= '0;
            x_r         <= '0;
            y_r         <= '0;
        end
    end

    // Retire pointer and count of results accepted downstream.
    always_ff @(posedge CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            out_ptr_r <= '0;
            res_cnt_r <= '0;
        end else if (start_acc_s) begin
            out_ptr_r <= '0;
            res_cnt_r <= '0;
        end else if (accept_s) begin
            out_ptr_r <= ptr_inc(out_ptr_r);
            res_cnt_r <= res_cnt_r + PIX_W'(1'b1);
        end
    end

    assign busy              = busy_r;
    assign frame_done        = frame_done_r;
    assign out_if.out_valid  = out_valid_s;
    assign out_if.out_data   = result_s[out_ptr_r];
    assign out_if.out_last   = out_valid_s && last_res_s;

`ifdef MANDEL_SCHED_PERF_EN
    logic [31:0] perf_cnt_r;
    logic [31:0] frame_cycles_r;

    // Busy-cycle counter, latched into frame_cycles once the frame is done.
    always_ff @(posedge CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            perf_cnt_r     <= 32'd0;
            frame_cycles_r <= 32'd0;
        end else begin
            if (start_acc_s) begin
                perf_cnt_r <= 32'd0;
            end else if (busy_r) begin
                perf_cnt_r <= sat_inc32(perf_cnt_r);
            end
            if (state_r == FRM_DONE) begin
                frame_cycles_r <= perf_cnt_r;
            end
        end
    end

    assign frame_cycles = frame_cycles_r;
`else
    assign frame_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mandel_point_scheduler.sv
`timescale 1ns/1ps
module tb_mandel_point_scheduler;

    localparam int NU  = 4;
    localparam int HBI = 32;
    localparam int CW  = 12;

    logic                CLK = 1'b0;
    logic                SYS_RESET_N = 1'b0;
    logic                frame_start = 1'b0;
    logic [10:0]         x_size = 11'd0;
    logic [10:0]         y_size = 11'd0;
    logic                busy;
    logic                frame_done;
    logic [NU-1:0]       unit_start;
    logic [NU*CW-1:0]    unit_x;
    logic [NU*CW-1:0]    unit_y;
    logic [NU-1:0]       unit_done = '0;
    logic [NU*HBI-1:0]   unit_iter = '0;
    logic [31:0]         frame_cycles;

    mandel_point_scheduler_if #(.HBI(HBI)) out_if ();

    mandel_point_scheduler #(.NUM_UNITS(NU), .HBI(HBI), .CW(CW)) dut (
        .CLK          (CLK),
        .SYS_RESET_N  (SYS_RESET_N),
        .frame_start  (frame_start),
        .x_size       (x_size),
        .y_size       (y_size),
        .busy         (busy),
        .frame_done   (frame_done),
        .unit_start   (unit_start),
        .unit_x       (unit_x),
        .unit_y       (unit_y),
        .unit_done    (unit_done),
        .unit_iter    (unit_iter),
        .out_if       (out_if),
        .frame_cycles (frame_cycles)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    int          lat [NU];
    int          cnt [NU];
    logic [31:0] iter_v [NU];
    logic [31:0] exp_q [$];
    int ex, ey, cur_xs, cur_ys;
    int n_start, n_out, busy_cnt;
    bit rnd_ready = 1'b0;

    typedef struct {
        int xs; int ys;
        int l0; int l1; int l2; int l3;
        bit rnd;
        int exp_n;
        int exp_done;   // cycle of frame_done after frame_start at cycle 0; 0 = not fixed
    } vec_t;

    vec_t vecs [7];

    function automatic logic [31:0] f_iter(input int x, input int y);
        f_iter = 32'(x * 7 + y * 1000 + 3);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rnd_ready) out_if.out_ready = 1'($urandom_range(0, 1));
    endtask

    // Unit models plus output scoreboard, evaluated mid-cycle.
    always @(negedge CLK) begin
        logic [31:0] e;
        if (busy) busy_cnt++;
        for (int k = 0; k < NU; k++) begin
            if (unit_start[k]) begin
                cnt[k] = lat[k];
                unit_done[k] = 1'b0;
                iter_v[k] = f_iter(int'(unit_x[k*CW +: CW]), int'(unit_y[k*CW +: CW]));
                exp_q.push_back(f_iter(ex, ey));
                n_start++;
                if (ex == cur_xs - 1) begin ex = 0; ey++; end
                else ex++;
            end else if (cnt[k] > 0) begin
                cnt[k]--;
                if (cnt[k] == 0) unit_done[k] = 1'b1;
            end
            unit_iter[k*HBI +: HBI] = unit_done[k] ? iter_v[k] : (32'hDEAD_0000 + 32'(k));
        end
        if (out_if.out_valid && out_if.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got data %0h with empty scoreboard", out_if.out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_if.out_data, e);
                check("out_last", out_if.out_last, (n_out == cur_xs * cur_ys - 1));
            end
            n_out++;
        end
    end

    task automatic set_lat(input int a, input int b, input int c, input int d);
        lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
    endtask

    task automatic start_frame(input int xs, input int ys);
        cur_xs = xs; cur_ys = ys; ex = 0; ey = 0;
        exp_q.delete();
        n_start = 0; n_out = 0; busy_cnt = 0;
        x_size = 11'(xs); y_size = 11'(ys);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic finish_frame(input int n, input int exp_done, input int cyc0);
        int cyc;
        cyc = cyc0;
        while (!frame_done && cyc < 3000) begin
            tick();
            cyc++;
        end
        check("frame_done_seen", frame_done, 1'b1);
        if (exp_done > 0) check("done_cycle", cyc, exp_done);
        check("busy_at_done", busy, 1'b0);
        check("start_count", n_start, n);
        check("result_count", n_out, n);
        check("scoreboard_empty", exp_q.size(), 0);
        tick();
        check("done_pulse_width", frame_done, 1'b0);
`ifdef MANDEL_SCHED_PERF_EN
        check("frame_cycles", frame_cycles, busy_cnt);
`else
        check("frame_cycles", frame_cycles, 32'd0);
`endif
        rnd_ready = 1'b0;
        out_if.out_ready = 1'b1;
    endtask

    initial begin
        int cyc;
        vecs[0] = '{xs:4,  ys:2, l0:5, l1:5, l2:5, l3:5, rnd:1'b0, exp_n:8,   exp_done:19};
        vecs[1] = '{xs:1,  ys:1, l0:1, l1:1, l2:1, l3:1, rnd:1'b0, exp_n:1,   exp_done:4};
        vecs[2] = '{xs:0,  ys:3, l0:1, l1:1, l2:1, l3:1, rnd:1'b0, exp_n:0,   exp_done:1};
        vecs[3] = '{xs:7,  ys:0, l0:1, l1:1, l2:1, l3:1, rnd:1'b0, exp_n:0,   exp_done:1};
        vecs[4] = '{xs:5,  ys:3, l0:2, l1:7, l2:1, l3:4, rnd:1'b1, exp_n:15,  exp_done:0};
        vecs[5] = '{xs:13, ys:9, l0:1, l1:1, l2:1, l3:1, rnd:1'b0, exp_n:117, exp_done:0};
        vecs[6] = '{xs:3,  ys:1, l0:3, l1:9, l2:2, l3:2, rnd:1'b1, exp_n:3,   exp_done:0};

        for (int k = 0; k < NU; k++) begin cnt[k] = 0; iter_v[k] = 32'd0; end
        set_lat(1, 1, 1, 1);
        cur_xs = 1; cur_ys = 1; ex = 0; ey = 0;
        n_start = 0; n_out = 0; busy_cnt = 0;
        out_if.out_ready = 1'b1;

        // Reset values.
        tick(); tick();
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_unit_start", unit_start, '0);
        check("rst_unit_x", unit_x, '0);
        check("rst_out_valid", out_if.out_valid, 1'b0);
        check("rst_out_data", out_if.out_data, 32'd0);
        check("rst_out_last", out_if.out_last, 1'b0);
        check("rst_frame_cycles", frame_cycles, 32'd0);
        SYS_RESET_N = 1'b1;
        tick();

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            set_lat(vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].l3);
            rnd_ready = 1'b0;
            out_if.out_ready = 1'b1;
            start_frame(vecs[i].xs, vecs[i].ys);
            check("cycle1_busy", busy, (vecs[i].exp_n > 0));
            check("cycle1_unit_start", unit_start, (vecs[i].exp_n > 0) ? 4'b0001 : 4'b0000);
            check("cycle1_xy", {unit_x[CW-1:0], unit_y[CW-1:0]}, 24'd0);
            rnd_ready = vecs[i].rnd;
            finish_frame(vecs[i].exp_n, vecs[i].exp_done, 1);
        end

        // Out-of-order completion: unit 2 finishes long before unit 0.
        set_lat(20, 6, 3, 6);
        start_frame(4, 1);
        cyc = 1;
        while (cyc < 10) begin tick(); cyc++; end
        check("ooo_held_back", out_if.out_valid, 1'b0);
        check("ooo_starts", n_start, 4);
        finish_frame(4, 26, cyc);

        // Back-pressure with every slot holding a result.
        set_lat(2, 2, 2, 2);
        out_if.out_ready = 1'b0;
        start_frame(4, 2);
        cyc = 1;
        while (cyc < 8) begin tick(); cyc++; end
        for (int i = 0; i < 10; i++) begin
            check("stall_no_start", unit_start, 4'b0000);
            check("stall_valid", out_if.out_valid, 1'b1);
            check("stall_data", out_if.out_data, f_iter(0, 0));
            tick();
            cyc++;
        end
        check("stall_issued", n_start, 4);
        out_if.out_ready = 1'b1;
        finish_frame(8, 0, cyc);

        // Reset in the middle of a frame, then a clean frame.
        set_lat(3, 3, 3, 3);
        start_frame(8, 2);
        cyc = 1;
        while (n_start < 5 && cyc < 200) begin tick(); cyc++; end
        check("mid_issues", n_start, 5);
        SYS_RESET_N = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_frame_done", frame_done, 1'b0);
        check("mid_rst_unit_start", unit_start, 4'b0000);
        check("mid_rst_unit_xy", {unit_x, unit_y}, '0);
        check("mid_rst_out_valid", out_if.out_valid, 1'b0);
        check("mid_rst_out_data", out_if.out_data, 32'd0);
        check("mid_rst_out_last", out_if.out_last, 1'b0);
        check("mid_rst_frame_cycles", frame_cycles, 32'd0);
        tick(); tick();
        SYS_RESET_N = 1'b1;
        tick();
        set_lat(5, 5, 5, 5);
        start_frame(4, 2);
        check("post_rst_start", unit_start, 4'b0001);
        finish_frame(8, 19, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
